// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and constants for the PC sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, HALTED} pcseq_state_t;
  localparam int PC_STEP = 4;
  localparam int CNT_W = 16;
endpackage

// File: rtl/flush_timer.sv
// flush_timer: 3-bit loadable down-counter that runs to zero and stops
module flush_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       busy,
  output logic       last
);
  logic [2:0] cnt_q, cnt_d;
  assign busy = |cnt_q;
  assign last = cnt_q == 3'd1;
  always_comb cnt_d = load ? load_val : (busy ? cnt_q - 3'd1 : cnt_q);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC controller with redirect flush, stall hold and halt/resume
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             flag_halt,
  input  logic             resume,
  output logic [PC_W-1:0]  PC,
  output logic             flush,
  output logic             halted,
  output logic             misalign,
  output logic             oor,
  output logic [CNT_W-1:0] redirect_cnt
);
  localparam logic [2:0] T_INIT = 3'(FLUSH_CYC - 1);
  localparam logic LONG_FLUSH = FLUSH_CYC > 1;
  pcseq_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, target;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mis_q, mis_d, oor_q, oor_d;
  logic t_load, t_busy, t_last;
  assign pc_inc = pc_q + PC_W'(PC_STEP);
  assign target = {BrPC[PC_W-1:2], 2'b00};
  assign PC = pc_q;
  assign halted = state_q == HALTED;
  assign misalign = mis_q;
  assign oor = oor_q;
  assign redirect_cnt = cnt_q;
  flush_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (T_INIT),
    .busy     (t_busy),
    .last     (t_last)
  );
  // Redirect beats halt and stall; in FLUSH the squashed PcSel/flag_halt are ignored
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    mis_d = mis_q;
    oor_d = oor_q;
    t_load = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (PcSel) begin
          pc_d = target;
          flush = 1'b1;
          cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
          mis_d = mis_q | (|BrPC[1:0]);
          oor_d = oor_q | (|BrPC[31:PC_W]);
          t_load = LONG_FLUSH;
          state_d = LONG_FLUSH ? FLUSH : RUN;
        end else if (flag_halt) state_d = HALTED;
        else if (!stall) pc_d = pc_inc;
      end
      FLUSH: begin
        flush = 1'b1;
        pc_d = stall ? pc_q : pc_inc;
        state_d = (t_last || !t_busy) ? RUN : FLUSH;
      end
      HALTED: state_d = resume ? RUN : HALTED;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      oor_q <= oor_d;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized checks against a behavioural PC model
module tb_pc_sequencer;
  localparam int PC_W = 9;
  localparam int FLUSH_CYC = 2;
  localparam int PC_MOD = 1 << PC_W;
  logic clk = 1'b0;
  logic reset, stall, PcSel, flag_halt, resume;
  logic [31:0] BrPC;
  logic [PC_W-1:0] PC;
  logic flush, halted, misalign, oor;
  logic [15:0] redirect_cnt;
  int checks = 0, errors = 0;
  int m_pc = 0, m_left = 0, m_cnt = 0;
  bit m_halted = 0, m_mis = 0, m_oor = 0;
  pc_sequencer #(.PC_W(PC_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .PcSel        (PcSel),
    .BrPC         (BrPC),
    .flag_halt    (flag_halt),
    .resume       (resume),
    .PC           (PC),
    .flush        (flush),
    .halted       (halted),
    .misalign     (misalign),
    .oor          (oor),
    .redirect_cnt (redirect_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit s, input bit ps, input bit fh, input bit rs,
                      input logic [31:0] br);
    reset = r;
    stall = s;
    PcSel = ps;
    flag_halt = fh;
    resume = rs;
    BrPC = br;
    @(negedge clk);
    if (!r) check("flush", flush, 32'(m_left > 0 || (!m_halted && ps)));
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_left = 0; m_cnt = 0; m_halted = 0; m_mis = 0; m_oor = 0;
    end else if (m_halted) begin
      if (rs) m_halted = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (!s) m_pc = (m_pc + 4) % PC_MOD;
    end else if (ps) begin
      m_pc = int'(br % PC_MOD) / 4 * 4;
      if (m_cnt < 65535) m_cnt++;
      if (br % 4 != 0) m_mis = 1;
      if (br >= PC_MOD) m_oor = 1;
      m_left = FLUSH_CYC - 1;
    end else if (fh) m_halted = 1;
    else if (!s) m_pc = (m_pc + 4) % PC_MOD;
    #1;
    check("pc", 32'(PC), m_pc);
    check("halted", 32'(halted), 32'(m_halted));
    check("misalign", 32'(misalign), 32'(m_mis));
    check("oor", 32'(oor), 32'(m_oor));
    check("redirect_cnt", 32'(redirect_cnt), m_cnt);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 1, 32'h40);
    check("reset_pc", 32'(PC), 0);
    run(4);
    check("seq_pc", 32'(PC), 16);
    step(0, 0, 1, 0, 0, 32'h40);
    check("branch_pc", 32'(PC), 32'h40);
    step(0, 0, 1, 0, 0, 32'h100);
    check("flush_ignore_pc", 32'(PC), 32'h44);
    run(1);
    check("branch_cnt", 32'(redirect_cnt), 1);
    step(1, 0, 0, 0, 0, 0);
    run(6);
    step(0, 0, 0, 1, 0, 0);
    check("halt_pc", 32'(PC), 24);
    for (int i = 0; i < 10; i++) step(0, i % 3 == 0, i % 2 == 0, i % 4 == 1, 0, 32'h80);
    check("halt_hold_pc", 32'(PC), 24);
    step(0, 0, 0, 0, 1, 0);
    check("resume_halted", 32'(halted), 0);
    run(1);
    check("resume_pc", 32'(PC), 28);
    step(0, 1, 1, 1, 0, 32'h80);
    check("prio_pc", 32'(PC), 32'h80);
    run(2);
    step(0, 0, 1, 0, 0, 32'h106);
    check("mis_pc", 32'(PC), 32'h104);
    run(2);
    step(0, 0, 1, 0, 0, 32'h400);
    check("oor_pc", 32'(PC), 0);
    run(5);
    check("flags_sticky", {30'd0, misalign, oor}, 3);
    step(0, 0, 1, 0, 0, 32'h20);
    step(1, 0, 0, 0, 0, 0);
    run(1);
    step(1, 0, 0, 0, 0, 0);
    run(127);
    check("wrap_pre", 32'(PC), 508);
    run(1);
    check("wrap_pc", 32'(PC), 0);
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] br;
      br = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h1FC);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, br);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program-counter controller that owns the PC register and sequences it from the branch resolution outputs (`PcSel`, `BrPC`) and the halt flag. It chooses between sequential advance, branch/jump redirect, stall hold and halt. On a redirect it squashes the wrong-path instructions through a timed flush. It sits between the execute-stage branch logic and the instruction memory address port.

## Interface
Parameters:
- `PC_W` = 9 — PC width in bits; instruction memory is byte-addressed and word-aligned.
- `FLUSH_CYC` = 2 — cycles the flush outputs stay asserted per redirect; legal range 1..7.

Ports:
- `clk` in 1 — the single clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `stall` in 1 — hazard stall from the hazard unit; holds the PC.
- `PcSel` in 1 — branch/jump taken, from the execute stage.
- `BrPC` in 32 — redirect target; valid when `PcSel`=1.
- `flag_halt` in 1 — halt instruction has reached execute.
- `resume` in 1 — one-cycle pulse that leaves the halted state.
- `PC` out PC_W — current fetch address.
- `flush` out 1 — squash IF/ID and ID/EX pipeline registers.
- `halted` out 1 — the core is halted.
- `misalign` out 1 — sticky; set when a redirect target has `BrPC[1:0]`≠0.
- `oor` out 1 — sticky; set when a redirect target has `BrPC[31:PC_W]`≠0.
- `redirect_cnt` out 16 — number of accepted redirects; saturates at 16'hFFFF.

## Operation
- FSM states: RUN, FLUSH, HALTED. Reset state is RUN.
- Reset values: `PC`=0, `flush`=0, `halted`=0, `misalign`=0, `oor`=0, `redirect_cnt`=0, flush timer=0.
- **RUN**, priority order:
  1. `PcSel`=1: this is a redirect. Next PC = `{BrPC[PC_W-1:2],2'b00}`. `flush`=1 in the same cycle (combinational). `redirect_cnt` increments. Update `misalign`/`oor` if the target is bad. If `FLUSH_CYC`>1, load the timer with `FLUSH_CYC`-1 and go to FLUSH; otherwise stay in RUN.
  2. `flag_halt`=1: PC holds and the FSM goes to HALTED. `halted` becomes 1 from the next cycle.
  3. `stall`=1: PC holds.
  4. Otherwise: PC += 4, modulo 2^PC_W, so (2^PC_W)-4 wraps to 0.
- **FLUSH**:
  - `flush`=1 every cycle; the timer decrements each cycle.
  - `PcSel` and `flag_halt` are ignored, because they come from squashed instructions.
  - PC += 4 unless `stall`=1.
  - When the timer reaches 1, go to RUN at the next edge.
- **HALTED**:
  - PC frozen, `flush`=0, `halted`=1.
  - `PcSel`, `flag_halt` and `stall` are ignored.
  - `resume`=1: go to RUN with the PC unchanged, and `halted`=0 from the next cycle.
- Simultaneous events:
  - `PcSel` with `flag_halt` in RUN: the redirect wins and the halt is discarded.
  - `PcSel` with `stall` in RUN: the redirect wins.
  - `resume` outside HALTED: ignored.
- `misalign` and `oor` clear only on `reset`.
- `reset` mid-flush or mid-halt returns everything to reset values on that edge, with no residual `flush`.

## Timing
- Redirect latency: `PcSel` is sampled at edge N, and `PC`=target after edge N.
- `flush` is high for exactly `FLUSH_CYC` consecutive cycles, starting in the cycle `PcSel` is seen.
- Halt: `flag_halt` at edge N gives `halted`=1 after edge N. The PC has the same value before and after edge N.
- Resume: `resume` at edge N means the PC advances at edge N+1, unless a stall or redirect applies.
- `PC`, `halted`, `misalign`, `oor` and `redirect_cnt` are registered outputs. `flush` is the only Mealy output.

## Structure
- Package `pc_seq_pkg`:
  - `typedef enum logic [1:0] {RUN, FLUSH, HALTED} pcseq_state_t`
  - `localparam PC_STEP = 4`
  - `localparam CNT_W = 16`
- Sub-module `flush_timer`:
  - 3-bit down-counter with `load`, `load_val` and `busy`/`last` outputs.
  - Instantiated once, driven by the FSM.
- The top module holds the FSM, the PC register, the sticky flags and the saturating counter.

## Test plan
- **Reset and sequential fetch:** release reset with `stall`=0 → `PC` goes 0, 4, 8, 12. At PC=508 (PC_W=9) the next PC is 0.
- **Taken branch:** at PC=16, pulse `PcSel` with `BrPC`=0x40 → `PC`=0x40 next cycle. `flush` is high for 2 cycles, a second `PcSel` during FLUSH is ignored, and `redirect_cnt`=1.
- **Halt and resume:** at PC=24, raise `flag_halt` → `halted`=1 and `PC` stays at 24 for 10 cycles while `PcSel` toggles. Pulse `resume` → `halted`=0 and `PC` goes 24, then 28.
- **Priority:** in RUN, assert `PcSel`, `flag_halt` and `stall` together with `BrPC`=0x80 → `PC`=0x80, `halted`=0, `flush`=1.
- **Bad targets:** `BrPC`=0x106 → `PC`=0x104 and `misalign`=1. `BrPC`=0x400 → `PC`=0 and `oor`=1. Both flags stay set until `reset`.
- **Reset mid-flush:** assert `reset` in the second flush cycle → after the edge `flush`=0, `PC`=0, state RUN, and the counter and flags are 0.
